// File: rtl/timer_delay.sv
// rtl/timer_delay.sv - programmable one-shot delay timer (IDLE/RUN/DONE) with prescaled tick counter
module timer_delay #(
    parameter int N        = 16,
    parameter int PRESCALE = 1000
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         START,
    input  logic [N-1:0] DELAY,
    input  logic         CANCEL,
    output logic         RDY,
    output logic         EXPIRED,
    output logic         BUSY,
    output logic [N-1:0] COUNT
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t         r_state;
    state_t         w_next;
    logic [N-1:0]   r_count;
    logic [PW-1:0]  r_pre;
    logic           w_tick;
    logic           w_last;
    logic           w_load;

    assign w_tick = (r_pre == PRE_LAST);
    assign w_last = w_tick && (r_count == N'(1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // DONE accepts a new START exactly like IDLE so back-to-back delays have no gap
    always_comb begin
        w_next = S_IDLE;
        w_load = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (!CANCEL && START) begin
                    if (DELAY != '0) begin
                        w_next = S_RUN;
                        w_load = 1'b1;
                    end else begin
                        w_next = S_DONE;
                    end
                end
            end
            S_RUN: begin
                if (CANCEL) begin
                    w_next = S_IDLE;
                end else if (w_last) begin
                    w_next = S_DONE;
                end else begin
                    w_next = S_RUN;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
            r_pre   <= '0;
        end else if (w_load) begin
            r_count <= DELAY;
            r_pre   <= '0;
        end else if (r_state == S_RUN && !CANCEL) begin
            if (w_tick) begin
                r_pre   <= '0;
                r_count <= r_count - N'(1);
            end else begin
                r_pre   <= r_pre + PW'(1);
            end
        end else begin
            r_count <= '0;
            r_pre   <= '0;
        end
    end

    assign BUSY    = (r_state == S_RUN);
    assign RDY     = (r_state != S_RUN);
    assign EXPIRED = (r_state == S_DONE);
    assign COUNT   = (r_state == S_RUN) ? r_count : '0;

endmodule
